// File: rtl/wb2ahb_pkg.sv
// Shared types and AHB-Lite encodings for the Wishbone-to-AHB bridge.
package wb2ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/wb2ahb_sel_decode.sv
// Maps Wishbone byte selects onto an AHB transfer size and address low bits.
module wb2ahb_sel_decode
  import wb2ahb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  localparam int SEL_W      = DATA_WIDTH / 8,
  localparam int LSB_W      = $clog2(SEL_W)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [2:0]       o_hsize,
  output logic [LSB_W-1:0] o_addr_lsb,
  output logic             o_legal
);

  // Zero-extending to four lanes lets one table serve both 16- and 32-bit buses.
  logic [3:0] w_sel4;
  assign w_sel4 = 4'(i_sel);

  always_comb begin
    o_hsize    = HSIZE_BYTE;
    o_addr_lsb = '0;
    o_legal    = 1'b0;
    case (w_sel4)
      4'b0001: o_legal = 1'b1;
      4'b0010: begin o_legal = 1'b1; o_addr_lsb = LSB_W'(1); end
      4'b0100: begin o_legal = 1'b1; o_addr_lsb = LSB_W'(2); end
      4'b1000: begin o_legal = 1'b1; o_addr_lsb = LSB_W'(3); end
      4'b0011: begin o_legal = 1'b1; o_hsize = HSIZE_HALF; end
      4'b1100: begin o_legal = 1'b1; o_hsize = HSIZE_HALF; o_addr_lsb = LSB_W'(2); end
      4'b1111: begin o_legal = 1'b1; o_hsize = HSIZE_WORD; end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb2ahb_bridge.sv
// Wishbone classic slave to AHB-Lite master: one request at a time, issued as a single NONSEQ.
//   state | meaning
//   IDLE  | waiting for cyc_i & stb_i
//   ADDR  | AHB address phase, NONSEQ driven until hready
//   DATA  | AHB data phase, hwdata driven until hready
//   RESP  | ack_o or err_o visible to the initiator
//   ERR   | illegal byte-select pattern, err_o visible, no AHB transfer
module wb2ahb_bridge
  import wb2ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [1:0]              htrans,
  output logic                    hwrite,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [3:0]              hprot,
  output logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH-1:0]   hrdata,
  input  logic                    hready,
  input  logic                    hresp
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int LSB_W = $clog2(SEL_W);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(SEL_W - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    w_req;
  logic [2:0]              w_hsize;
  logic [LSB_W-1:0]        w_addr_lsb;
  logic                    w_legal;
  logic [ADDR_WIDTH-1:0]   w_haddr;

  wb2ahb_sel_decode #(.DATA_WIDTH(DATA_WIDTH)) u_sel_decode (
    .i_sel      (sel_i),
    .o_hsize    (w_hsize),
    .o_addr_lsb (w_addr_lsb),
    .o_legal    (w_legal)
  );

  assign w_req   = cyc_i & stb_i;
  assign w_haddr = (adr_i & ~LSB_MASK) | ADDR_WIDTH'(w_addr_lsb);
  assign hburst  = HBURST_SINGLE;
  assign hprot   = HPROT_DEFAULT;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = w_legal ? ST_ADDR : ST_ERR;
      ST_ADDR: if (hready) w_next = ST_DATA;
      ST_DATA: if (hready) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      htrans  <= HTRANS_IDLE;
      haddr   <= '0;
      hwrite  <= 1'b0;
      hsize   <= HSIZE_BYTE;
      hwdata  <= '0;
      r_wdata <= '0;
      dat_o   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_legal) begin
              htrans  <= HTRANS_NONSEQ;
              haddr   <= w_haddr;
              hwrite  <= we_i;
              hsize   <= w_hsize;
              r_wdata <= dat_i;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            hwdata <= r_wdata;
          end
        end
        ST_DATA: begin
          // Termination is decided here so it is already registered during RESP.
          if (hready) begin
            if (!hwrite && (hresp == HRESP_OKAY)) dat_o <= hrdata;
            ack_o <= cyc_i & (hresp == HRESP_OKAY);
            err_o <= cyc_i & (hresp == HRESP_ERROR);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2ahb_bridge.sv
// Self-checking bench for wb2ahb_bridge: directed scenarios plus randomized transactions vs a reference model.
module tb_wb2ahb_bridge;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int SW = DW / 8;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          cyc_i, stb_i, we_i;
  logic [AW-1:0] adr_i;
  logic [DW-1:0] dat_i;
  logic [SW-1:0] sel_i;
  logic [DW-1:0] dat_o;
  logic          ack_o, err_o;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata, hrdata;
  logic          hready, hresp;

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] exp_dat;

  int            o_nonseq, o_ack, o_err, o_lat;
  bit            o_both, o_unstable;
  logic [AW-1:0] o_haddr;
  logic [2:0]    o_hsize;
  logic          o_hwrite;
  logic [DW-1:0] o_hwdata;
  logic [1:0]    o_htrans_data;

  wb2ahb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // Reference decode from the byte-lane rules: count lanes, find lowest lane.
  function automatic void ref_decode(input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                                     output bit legal, output logic [2:0] size,
                                     output logic [AW-1:0] addr);
    int n, k, low;
    n = 0; k = -1; low = 0;
    for (int i = 0; i < SW; i++) if (sel[i]) begin n++; if (k < 0) k = i; end
    legal = 1'b0; size = 3'b000;
    if (n == 1) begin legal = 1'b1; low = k; end
    else if (n == 2 && (k % 2) == 0 && sel[k+1]) begin legal = 1'b1; size = 3'b001; low = k; end
    else if (n == 4) begin legal = 1'b1; size = 3'b010; end
    addr = (adr / AW'(SW)) * AW'(SW) + AW'(low);
  endfunction

  // Drives one Wishbone request and plays the AHB slave on a cycle schedule; records what it saw.
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] sel, input int aw, input int dw,
                         input logic eresp, input logic [DW-1:0] rd, input int drop_at);
    int ncyc;
    ncyc = aw + dw + 8;
    o_nonseq = 0; o_ack = 0; o_err = 0; o_lat = -1; o_both = 0; o_unstable = 0;
    o_haddr = '0; o_hsize = '0; o_hwrite = 1'b0; o_hwdata = '0; o_htrans_data = 2'bxx;
    @(negedge hclk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
    hready = 1'b1; hresp = 1'b0;
    @(posedge hclk);
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      hready = 1'b1; hresp = 1'b0; hrdata = DW'($urandom);
      if (c <= aw) hready = 1'b0;
      else if (c > aw + 1 && c <= aw + 1 + dw) begin
        hready = 1'b0;
        if (eresp && c == aw + 1 + dw) hresp = 1'b1;
      end else if (c == aw + dw + 2) begin
        hresp = eresp; hrdata = rd;
      end
      if (c == drop_at) begin cyc_i = 1'b0; stb_i = 1'b0; end
      @(negedge hclk);
      if (htrans == 2'b10) begin
        if (o_nonseq == 0) begin o_haddr = haddr; o_hsize = hsize; o_hwrite = hwrite; end
        else if (haddr !== o_haddr || hsize !== o_hsize || hwrite !== o_hwrite) o_unstable = 1;
        o_nonseq++;
      end
      if (c == aw + dw + 2) begin o_hwdata = hwdata; o_htrans_data = htrans; end
      if (ack_o === 1'b1) begin o_ack++; if (o_lat < 0) o_lat = c; end
      if (err_o === 1'b1) begin o_err++; if (o_lat < 0) o_lat = c; end
      if (ack_o === 1'b1 && err_o === 1'b1) o_both = 1;
      if (ack_o === 1'b1 || err_o === 1'b1) begin cyc_i = 1'b0; stb_i = 1'b0; end
      @(posedge hclk);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0; sel_i = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #2 hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checks++; if (htrans !== 2'b00) $display("FAIL rst_htrans got %b want 00", htrans); else passes++;
    checks++; if (haddr !== '0) $display("FAIL rst_haddr got %h want 0", haddr); else passes++;
    checks++; if (hwrite !== 1'b0) $display("FAIL rst_hwrite got %b want 0", hwrite); else passes++;
    checks++; if (hsize !== 3'b000) $display("FAIL rst_hsize got %b want 000", hsize); else passes++;
    checks++; if (hwdata !== '0) $display("FAIL rst_hwdata got %h want 0", hwdata); else passes++;
    checks++; if (dat_o !== '0) $display("FAIL rst_dat_o got %h want 0", dat_o); else passes++;
    checks++; if (ack_o !== 1'b0 || err_o !== 1'b0) $display("FAIL rst_term got ack=%b err=%b want 0/0", ack_o, err_o); else passes++;
    checks++; if (hburst !== 3'b000) $display("FAIL hburst got %b want 000", hburst); else passes++;
    checks++; if (hprot !== 4'b0011) $display("FAIL hprot got %b want 0011", hprot); else passes++;
    hresetn = 1'b1;
    exp_dat = '0;
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 32'h0000_1000, 16'hA5C3, 2'b11, 0, 0, 1'b0, '0, 0);
    checks++; if (o_haddr !== 32'h1000) $display("FAIL wr_haddr got %h want 00001000", o_haddr); else passes++;
    checks++; if (o_hsize !== 3'b001) $display("FAIL wr_hsize got %b want 001", o_hsize); else passes++;
    checks++; if (o_hwrite !== 1'b1) $display("FAIL wr_hwrite got %b want 1", o_hwrite); else passes++;
    checks++; if (o_hwdata !== 16'hA5C3) $display("FAIL wr_hwdata got %h want a5c3", o_hwdata); else passes++;
    checks++; if (o_htrans_data !== 2'b00) $display("FAIL wr_htrans_data got %b want 00", o_htrans_data); else passes++;
    checks++; if (o_lat !== 3 || o_ack !== 1 || o_err !== 0) $display("FAIL wr_ack got lat=%0d ack=%0d err=%0d want 3/1/0", o_lat, o_ack, o_err); else passes++;
  endtask

  task automatic test_read_waits();
    run_txn(1'b0, 32'h0000_2000, 16'h0000, 2'b10, 0, 2, 1'b0, 16'h7E00, 0);
    exp_dat = 16'h7E00;
    checks++; if (o_haddr !== 32'h2001) $display("FAIL rd_haddr got %h want 00002001", o_haddr); else passes++;
    checks++; if (o_hsize !== 3'b000 || o_hwrite !== 1'b0) $display("FAIL rd_ctrl got size=%b wr=%b want 000/0", o_hsize, o_hwrite); else passes++;
    checks++; if (dat_o !== exp_dat) $display("FAIL rd_dat_o got %h want %h", dat_o, exp_dat); else passes++;
    checks++; if (o_lat !== 5 || o_ack !== 1 || o_err !== 0) $display("FAIL rd_ack got lat=%0d ack=%0d err=%0d want 5/1/0", o_lat, o_ack, o_err); else passes++;
  endtask

  task automatic test_read_error();
    run_txn(1'b0, 32'h0000_2400, 16'h0000, 2'b01, 0, 1, 1'b1, 16'hDEAD, 0);
    checks++; if (o_err !== 1 || o_ack !== 0 || o_both) $display("FAIL rderr_term got ack=%0d err=%0d want 0/1", o_ack, o_err); else passes++;
    checks++; if (o_lat !== 4) $display("FAIL rderr_lat got %0d want 4", o_lat); else passes++;
    checks++; if (dat_o !== exp_dat) $display("FAIL rderr_dat_o got %h want %h", dat_o, exp_dat); else passes++;
  endtask

  task automatic test_illegal_sel();
    run_txn(1'b1, 32'h0000_5000, 16'hBEEF, 2'b00, 0, 0, 1'b0, '0, 0);
    checks++; if (o_lat !== 1 || o_err !== 1 || o_ack !== 0) $display("FAIL ill_term got lat=%0d ack=%0d err=%0d want 1/0/1", o_lat, o_ack, o_err); else passes++;
    checks++; if (o_nonseq !== 0) $display("FAIL ill_htrans got %0d nonseq cycles want 0", o_nonseq); else passes++;
  endtask

  task automatic test_cyc_drop();
    run_txn(1'b1, 32'h0000_6000, 16'h1357, 2'b11, 0, 3, 1'b0, '0, 2);
    checks++; if (o_ack !== 0 || o_err !== 0) $display("FAIL drop_term got ack=%0d err=%0d want 0/0", o_ack, o_err); else passes++;
    checks++; if (o_nonseq !== 1 || o_hwdata !== 16'h1357) $display("FAIL drop_ahb got nonseq=%0d hwdata=%h want 1/1357", o_nonseq, o_hwdata); else passes++;
    checks++; if (htrans !== 2'b00) $display("FAIL drop_idle got htrans %b want 00", htrans); else passes++;
    run_txn(1'b1, 32'h0000_6100, 16'h2468, 2'b01, 0, 0, 1'b0, '0, 0);
    checks++; if (o_lat !== 3 || o_ack !== 1 || o_haddr !== 32'h6100) $display("FAIL drop_next got lat=%0d ack=%0d haddr=%h want 3/1/00006100", o_lat, o_ack, o_haddr); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge hclk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0000_3000; dat_i = 16'h1234;
    sel_i = 2'b11; hready = 1'b1; hresp = 1'b0;
    @(posedge hclk);
    #1 hready = 1'b0;
    @(negedge hclk);
    checks++; if (htrans !== 2'b10) $display("FAIL rstmid_pre got htrans %b want 10", htrans); else passes++;
    #2 hresetn = 1'b0;
    #1;
    checks++; if (htrans !== 2'b00 || haddr !== '0 || hwrite !== 1'b0 || hsize !== 3'b000) $display("FAIL rstmid_ahb got htrans=%b haddr=%h hwrite=%b hsize=%b want reset", htrans, haddr, hwrite, hsize); else passes++;
    checks++; if (hwdata !== '0 || dat_o !== '0 || ack_o !== 1'b0 || err_o !== 1'b0) $display("FAIL rstmid_wb got hwdata=%h dat_o=%h ack=%b err=%b want 0", hwdata, dat_o, ack_o, err_o); else passes++;
    cyc_i = 1'b0; stb_i = 1'b0; hready = 1'b1;
    exp_dat = '0;
    @(negedge hclk);
    hresetn = 1'b1;
    run_txn(1'b1, 32'h0000_4002, 16'h0F0F, 2'b01, 0, 0, 1'b0, '0, 0);
    checks++; if (o_lat !== 3 || o_ack !== 1 || o_haddr !== 32'h4002 || o_hwdata !== 16'h0F0F) $display("FAIL rstmid_after got lat=%0d ack=%0d haddr=%h hwdata=%h want 3/1/00004002/0f0f", o_lat, o_ack, o_haddr, o_hwdata); else passes++;
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int ns[$];
    @(negedge hclk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0000_7000; dat_i = 16'h5555;
    sel_i = 2'b11; hready = 1'b1; hresp = 1'b0;
    @(posedge hclk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge hclk);
      if (htrans == 2'b10) ns.push_back(c);
      if (ack_o === 1'b1) acks.push_back(c);
      if (acks.size() == 2) begin cyc_i = 1'b0; stb_i = 1'b0; end
      @(posedge hclk);
    end
    checks++; if (acks.size() != 2 || acks[0] != 3 || acks[1] != 7) $display("FAIL b2b_acks got n=%0d first=%0d second=%0d want 2/3/7", acks.size(), (acks.size() > 0) ? acks[0] : -1, (acks.size() > 1) ? acks[1] : -1); else passes++;
    checks++; if (ns.size() != 2 || ns[0] != 1 || ns[1] != 5) $display("FAIL b2b_nonseq got n=%0d want 2 at cycles 1,5", ns.size()); else passes++;
  endtask

  task automatic test_random();
    logic          we, eresp;
    logic [AW-1:0] adr, eaddr;
    logic [DW-1:0] wd, rd;
    logic [SW-1:0] sel;
    logic [2:0]    esize;
    bit            legal;
    int            aw, dw, elat;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); adr = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
      sel = SW'($urandom_range(0, (1 << SW) - 1));
      aw = $urandom_range(0, 2); dw = $urandom_range(0, 2);
      eresp = ($urandom_range(0, 7) == 0);
      if (eresp && dw == 0) dw = 1;
      ref_decode(sel, adr, legal, esize, eaddr);
      run_txn(we, adr, wd, sel, aw, dw, eresp, rd, 0);
      if (legal && !we && !eresp) exp_dat = rd;
      elat = legal ? aw + dw + 3 : 1;
      checks++; if (o_lat !== elat) $display("FAIL rnd%0d_lat got %0d want %0d", i, o_lat, elat); else passes++;
      checks++; if (o_ack !== ((legal && !eresp) ? 1 : 0) || o_err !== ((!legal || eresp) ? 1 : 0) || o_both) $display("FAIL rnd%0d_term got ack=%0d err=%0d", i, o_ack, o_err); else passes++;
      checks++; if (o_nonseq !== (legal ? aw + 1 : 0) || o_unstable) $display("FAIL rnd%0d_nonseq got %0d unstable=%0d want %0d", i, o_nonseq, o_unstable, legal ? aw + 1 : 0); else passes++;
      checks++; if (dat_o !== exp_dat) $display("FAIL rnd%0d_dat_o got %h want %h", i, dat_o, exp_dat); else passes++;
      if (legal) begin
        checks++; if (o_haddr !== eaddr || o_hsize !== esize || o_hwrite !== we) $display("FAIL rnd%0d_addr got %h/%b/%b want %h/%b/%b", i, o_haddr, o_hsize, o_hwrite, eaddr, esize, we); else passes++;
        checks++; if (o_htrans_data !== 2'b00) $display("FAIL rnd%0d_htrans_data got %b want 00", i, o_htrans_data); else passes++;
        if (we) begin
          checks++; if (o_hwdata !== wd) $display("FAIL rnd%0d_hwdata got %h want %h", i, o_hwdata, wd); else passes++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_waits();
    test_read_error();
    test_illegal_sel();
    test_cyc_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no summary want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb2ahb_bridge.md
# wb2ahb_bridge

Wishbone classic slave to AHB-Lite master bridge; the reverse of the existing ahb2wb path. Accepts one Wishbone request at a time, issues it as a single NONSEQ AHB transfer, and returns data and status on the Wishbone side. It sits between a Wishbone initiator (CPU or DMA) and an AHB-Lite fabric, and shares its width parameters with the ahb2wb bench (32-bit address, 16-bit data).

## Interface
- ADDR_WIDTH, 32, Wishbone and AHB address width
- DATA_WIDTH, 16, Wishbone and AHB data width; legal values are 16 and 32
- hclk  in  1  sole clock, rising edge
- hresetn  in  1  reset, asynchronous assert, active-low
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  ADDR_WIDTH  byte address
- dat_i  in  DATA_WIDTH  write data
- sel_i  in  DATA_WIDTH/8  byte selects
- dat_o  out  DATA_WIDTH  read data
- ack_o  out  1  normal termination
- err_o  out  1  error termination
- haddr  out  ADDR_WIDTH  AHB address
- htrans  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- hwrite  out  1  AHB direction
- hsize  out  3  transfer size
- hburst  out  3  constant 3'b000 (SINGLE)
- hprot  out  4  constant 4'b0011
- hwdata  out  DATA_WIDTH  AHB write data
- hrdata  in  DATA_WIDTH  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response, 0=OKAY, 1=ERROR

## Operation
- FSM states and transitions:
  - IDLE: if cyc_i & stb_i, go to ADDR or ERR.
  - ADDR: hold until hready=1, then go to DATA.
  - DATA: hold until hready=1, then go to RESP.
  - RESP: go to IDLE.
  - ERR: go to IDLE.
- In IDLE with cyc_i & stb_i, register adr_i, we_i, dat_i and sel_i, then decode sel_i:
  - One-hot sel_i bit k gives hsize=000 and haddr low bits set to k.
  - Aligned halfword pair (sel_i=2'b11 for width 16; 4'b0011 or 4'b1100 for width 32) gives hsize=001 and haddr low bits set to 0 or 2.
  - All ones at width 32 gives hsize=010 and low bits 0.
  - Any other pattern, including zero, is illegal. Go to ERR, which pulses err_o; no AHB transfer is issued.
- ADDR drives htrans=NONSEQ plus haddr, hwrite and hsize. These hold stable while hready=0.
- DATA drives htrans=IDLE, and hwdata carries the registered write data for the whole phase.
- When DATA completes with hready=1:
  - Capture hrdata into dat_o on reads only.
  - Capture hresp.
- AHB two-cycle ERROR response: the first cycle has hresp=1 and hready=0 and is simply waited out. The captured hresp=1 makes RESP pulse err_o instead of ack_o.
- RESP pulses exactly one of ack_o or err_o, and only if cyc_i is still 1. If the initiator dropped cyc_i mid-transfer, the AHB transfer still completes (it cannot be aborted) and the termination is suppressed.
- dat_o holds its last value until the next read completes. For writes, dat_o is not updated.
- Back-to-back: stb_i still high in the IDLE cycle after RESP is treated as a new request, per Wishbone classic. No request is ever accepted while in a non-IDLE state.

## Timing
- Reset values: htrans=00, haddr=0, hwrite=0, hsize=000, hwdata=0, dat_o=0, ack_o=0, err_o=0, FSM=IDLE.
- Reset takes effect immediately on assertion, including mid-transfer; htrans returns to IDLE asynchronously.
- All outputs are registered.
- Zero-wait-state AHB: request sampled at edge E0, ADDR from E0, DATA from E1, ack_o high in the cycle after E2. Minimum latency is 3 cycles from acceptance to ack.
- Each AHB wait state adds one cycle in whichever phase it occurs.
- Illegal sel_i: err_o is high in the cycle after the acceptance edge.
- ack_o and err_o are single-cycle pulses and never high together.

## Structure
- Shared package wb2ahb_pkg holds:
  - the FSM state enum;
  - HTRANS_IDLE and HTRANS_NONSEQ;
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD;
  - HBURST_SINGLE and HPROT_DEFAULT;
  - HRESP_OKAY and HRESP_ERROR.
- One sub-module, wb2ahb_sel_decode: combinational; sel_i in; hsize, address low bits and a legal flag out.

## Test plan
- Write, DATA_WIDTH=16, adr_i=32'h0000_1000, sel_i=11, dat_i=16'hA5C3, hready=1 -> haddr=32'h1000, hsize=001, hwrite=1, hwdata=16'hA5C3; ack_o 3 cycles after acceptance.
- Read, sel_i=10, adr_i=32'h2000, hrdata=16'h7E00, 2 wait states in DATA -> haddr=32'h2001, hsize=000, dat_o=16'h7E00, ack_o 5 cycles after acceptance.
- Read with AHB ERROR (hresp=1/hready=0, then hresp=1/hready=1) -> err_o single pulse, ack_o stays 0, dat_o unchanged.
- sel_i=00 -> err_o the next cycle, htrans stays 00 throughout.
- cyc_i dropped during DATA with hready low for 3 cycles -> AHB transfer completes, no ack_o/err_o, FSM in IDLE.
- hresetn asserted in ADDR with hready=0 -> all outputs at reset values immediately. After release, a new write completes normally.
